// File: rtl/mem_bank_pkg.sv
// Shared types for the 1R1W bank responder: FSM state, read-stage flags, injection mask.
// No logic; imported by mem_1r1w_bank_resp.
// No flow control.
package mem_bank_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } bank_state_t;

    // Per-stage status carried alongside data/padr; the WIDTH/BITROW-sized fields
    // are packed next to it by the top because they depend on parameters.
    typedef struct packed {
        logic fwd;
        logic serr;
        logic derr;
    } rd_flags_t;

    localparam int ERRINJ_DERR_MASK = 3;

endpackage

// File: rtl/mem_rd_pipe.sv
// DEPTH-stage valid/payload shift register; payload of a stage only loads behind a valid entry.
// Latency DEPTH cycles from in_vld to out_vld.
// No backpressure: one entry accepted every cycle; the last payload holds while idle.
module mem_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [PW-1:0] in_dat,
    output logic          out_vld,
    output logic [PW-1:0] out_dat
);

    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    dat [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            if (in_vld) begin
                dat[0] <= in_dat;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_vld = vld[DEPTH-1];
    assign out_dat = dat[DEPTH-1];

endmodule

// File: rtl/mem_1r1w_bank_resp.sv
// Behavioural 1R1W SRAM bank with zero-fill init and write->read forwarding; MEM_1R1W_ERRINJ_EN adds error injection.
// Read latency SRAM_DELAY cycles from the readB cycle.
// No backpressure: one read and one write per cycle once ready; accesses during init are dropped.
module mem_1r1w_bank_resp
    import mem_bank_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUMROW     = 1024,
    parameter int BITROW     = 10,
    parameter int SRAM_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeA,
    input  logic [BITROW-1:0] addrA,
    input  logic [WIDTH-1:0]  dinA,
    input  logic              readB,
    input  logic [BITROW-1:0] addrB,
`ifdef MEM_1R1W_ERRINJ_EN
    input  logic              errinj_serr,
    input  logic              errinj_derr,
`endif
    output logic [WIDTH-1:0]  doutB,
    output logic              fwrdB,
    output logic              serrB,
    output logic              derrB,
    output logic [BITROW-1:0] padrB,
    output logic              ready
);

    localparam logic [BITROW:0]   ROWS     = (BITROW+1)'(NUMROW);
    localparam logic [BITROW-1:0] LAST_ROW = BITROW'(NUMROW - 1);
    localparam int                PW       = WIDTH + BITROW + $bits(rd_flags_t);

    bank_state_t       state;
    logic [BITROW-1:0] init_row;
    logic [WIDTH-1:0]  mem [NUMROW];

    logic              active;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              mem_we;
    logic [BITROW-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  rd_dat;
    rd_flags_t         rd_flags;
    logic              pipe_vld;
    logic [PW-1:0]     pipe_dat;
    rd_flags_t         out_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_row <= '0;
            ready    <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_row == LAST_ROW) begin
                state <= ST_READY;
                ready <= 1'b1;
            end else begin
                init_row <= init_row + 1'b1;
            end
        end
    end

    assign active      = (state == ST_READY);
    assign wr_in_range = ({1'b0, addrA} < ROWS);
    assign rd_in_range = ({1'b0, addrB} < ROWS);

    // The init sweep owns the write port until the last row is cleared.
    assign mem_we = !active || (writeA && wr_in_range);
    assign mem_wa = active ? addrA : init_row;
    assign mem_wd = active ? dinA : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        rd_flags = '0;
        rd_dat   = '0;
        if (rd_in_range) begin
            rd_flags.fwd = writeA && (addrA == addrB);
            rd_dat       = rd_flags.fwd ? dinA : mem[addrB];
        end
`ifdef MEM_1R1W_ERRINJ_EN
        if (errinj_derr) begin
            rd_flags.derr = 1'b1;
            rd_dat        = rd_dat ^ WIDTH'(ERRINJ_DERR_MASK);
        end else begin
            rd_flags.serr = errinj_serr;
        end
`endif
    end

    mem_rd_pipe #(
        .DEPTH (SRAM_DELAY),
        .PW    (PW)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (active && readB),
        .in_dat  ({rd_dat, addrB, rd_flags}),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    assign {doutB, padrB, out_flags} = pipe_dat;
    assign fwrdB = out_flags.fwd;
    assign serrB = pipe_vld && out_flags.serr;
    assign derrB = pipe_vld && out_flags.derr;

endmodule

// File: tb/tb_mem_1r1w_bank_resp.sv
// Scoreboard bench for mem_1r1w_bank_resp: a driver pushes model-predicted reads with their due cycle,
// a monitor pops and compares them, and checks output hold, ready and reset values every cycle.
module tb_mem_1r1w_bank_resp;

    localparam int WIDTH      = 32;
    localparam int NUMROW     = 12;
    localparam int BITROW     = 4;
    localparam int SRAM_DELAY = 2;

    typedef struct {
        int                due;
        logic [WIDTH-1:0]  d;
        logic              f;
        logic [BITROW-1:0] p;
        logic              s;
        logic              e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              writeA = 1'b0;
    logic [BITROW-1:0] addrA = '0;
    logic [WIDTH-1:0]  dinA = '0;
    logic              readB = 1'b0;
    logic [BITROW-1:0] addrB = '0;
    logic [WIDTH-1:0]  doutB;
    logic              fwrdB;
    logic              serrB;
    logic              derrB;
    logic [BITROW-1:0] padrB;
    logic              ready;
`ifdef MEM_1R1W_ERRINJ_EN
    logic              errinj_serr = 1'b0;
    logic              errinj_derr = 1'b0;
    bit                inj_s = 1'b0;
    bit                inj_d = 1'b0;
`endif

    int   cyc = 0;
    int   rel = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [WIDTH-1:0] mm [2**BITROW];

    mem_1r1w_bank_resp #(
        .WIDTH      (WIDTH),
        .NUMROW     (NUMROW),
        .BITROW     (BITROW),
        .SRAM_DELAY (SRAM_DELAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .writeA      (writeA),
        .addrA       (addrA),
        .dinA        (dinA),
        .readB       (readB),
        .addrB       (addrB),
`ifdef MEM_1R1W_ERRINJ_EN
        .errinj_serr (errinj_serr),
        .errinj_derr (errinj_derr),
`endif
        .doutB       (doutB),
        .fwrdB       (fwrdB),
        .serrB       (serrB),
        .derrB       (derrB),
        .padrB       (padrB),
        .ready       (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin : monitor
        exp_t hold;
        exp_t e;
        hold = '{default: 0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hold = '{default: 0};
                chk("rst_ready", 64'(ready), 0);
                chk("rst_dout", 64'(doutB), 0);
                chk("rst_fwrd", 64'(fwrdB), 0);
                chk("rst_padr", 64'(padrB), 0);
                chk("rst_serr", 64'(serrB), 0);
                chk("rst_derr", 64'(derrB), 0);
            end else begin
                chk("ready", 64'(ready), 64'(cyc >= rel + NUMROW));
                while (q.size() > 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    errors++;
                    checks++;
                    $display("FAIL missed_read: row %0d due cycle %0d not seen, now cycle %0d", e.p, e.due, cyc);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("rd_dout", 64'(doutB), 64'(e.d));
                    chk("rd_fwrd", 64'(fwrdB), 64'(e.f));
                    chk("rd_padr", 64'(padrB), 64'(e.p));
                    chk("rd_serr", 64'(serrB), 64'(e.s));
                    chk("rd_derr", 64'(derrB), 64'(e.e));
                    hold = e;
                end else begin
                    chk("hold_dout", 64'(doutB), 64'(hold.d));
                    chk("hold_fwrd", 64'(fwrdB), 64'(hold.f));
                    chk("hold_padr", 64'(padrB), 64'(hold.p));
                    chk("idle_serr", 64'(serrB), 0);
                    chk("idle_derr", 64'(derrB), 0);
                end
            end
        end
    end

    // One input cycle; the model resolves the read from the array as it was before this cycle's write.
    task automatic drive(input bit wr, input int wa, input logic [WIDTH-1:0] wd, input bit rd, input int ra);
        exp_t e;
        bit   act;
        @(negedge clk);
        writeA = wr;
        addrA  = BITROW'(wa);
        dinA   = wd;
        readB  = rd;
        addrB  = BITROW'(ra);
`ifdef MEM_1R1W_ERRINJ_EN
        errinj_serr = inj_s;
        errinj_derr = inj_d;
`endif
        act = (cyc >= rel + NUMROW);
        if (act && rd) begin
            e = '{default: 0};
            e.due = cyc + SRAM_DELAY;
            e.p   = BITROW'(ra);
            if (ra < NUMROW) begin
                if (wr && wa == ra) begin
                    e.d = wd;
                    e.f = 1'b1;
                end else begin
                    e.d = mm[ra];
                end
            end
`ifdef MEM_1R1W_ERRINJ_EN
            if (inj_d) begin
                e.d = e.d ^ 32'h3;
                e.e = 1'b1;
            end else if (inj_s) begin
                e.s = 1'b1;
            end
`endif
            q.push_back(e);
        end
        if (act && wr && wa < NUMROW) mm[wa] = wd;
`ifdef MEM_1R1W_ERRINJ_EN
        inj_s = 1'b0;
        inj_d = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, 0, 0);
    endtask

    task automatic noise(input int n);
        repeat (n) drive(1'($urandom), $urandom_range(0, 15), $urandom, 1'($urandom), $urandom_range(0, 15));
    endtask

    task automatic do_reset(input int hold_cycles);
        @(negedge clk);
        rst    = 1'b1;
        writeA = 1'b0;
        readB  = 1'b0;
        q.delete();
        repeat (hold_cycles) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 2**BITROW; i++) mm[i] = '0;
    endtask

    task automatic random_traffic(input int n);
        int ra;
        repeat (n) begin
            ra = $urandom_range(0, 15);
`ifdef MEM_1R1W_ERRINJ_EN
            inj_s = ($urandom_range(0, 7) == 0);
            inj_d = ($urandom_range(0, 7) == 0);
`endif
            drive(1'($urandom), ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15),
                  $urandom, ($urandom_range(0, 3) != 0), ra);
        end
    endtask

    initial begin : stimulus
        int waited;
        do_reset(3);
        noise(NUMROW);                         // dropped while the init sweep runs
        drive(0, 0, '0, 1, 5);                 // freshly cleared row
        drive(1, 3, 32'hDEADBEEF, 0, 0);
        drive(0, 0, '0, 1, 3);
        drive(1, 7, 32'h12345678, 1, 7);       // same-cycle forward
        drive(1, 7, 32'h0, 0, 0);              // overwrite while the read is in flight
        drive(0, 0, '0, 1, 7);
        drive(1, 13, 32'hAAAA5555, 0, 0);      // out of range: dropped
        drive(0, 0, '0, 1, 13);
        drive(1, 13, 32'h5555AAAA, 1, 13);
        for (int r = 0; r < 16; r++) drive(0, 0, '0, 1, r);
        random_traffic(400);
`ifdef MEM_1R1W_ERRINJ_EN
        drive(1, 2, 32'hF0, 0, 0);
        inj_d = 1'b1;
        drive(0, 0, '0, 1, 2);
        idle(2);
        inj_d = 1'b1;
        inj_s = 1'b1;
        drive(0, 0, '0, 1, 2);
        inj_s = 1'b1;
        drive(0, 0, '0, 1, 2);
        inj_s = 1'b1;
        drive(0, 0, '0, 0, 2);                 // no read: injection has no effect
        idle(3);
`endif
        drive(1, 4, 32'h0BADF00D, 1, 4);
        drive(0, 0, '0, 1, 4);
        do_reset(2);                           // reads still in flight
        noise(8);
        do_reset(1);                           // restart mid-sweep
        noise(NUMROW);
        for (int r = 0; r < 16; r++) drive(0, 0, '0, 1, r);
        random_traffic(300);
        for (int r = 0; r < 16; r++) drive(0, 0, '0, 1, r);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        idle(2);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d reads outstanding, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
